// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master (fetch/load-store) arbiter onto one SRAM-like bus, one outstanding transaction.
// Ports: clk, resetn (sync, active-low);
//   inst_req/inst_addr -> inst_addr_ok/inst_data_ok/inst_rdata (fetch, read only);
//   data_req/data_wr/data_wstrb/data_addr/data_wdata -> data_addr_ok/data_data_ok/data_rdata;
//   bus_req/bus_wr/bus_wstrb/bus_addr/bus_wdata out, bus_addr_ok/bus_data_ok/bus_rdata in.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data has fixed priority).
module sram_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic owner;
  logic pick_data;
  logic grant;
  logic done;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant;
  always_ff @(posedge clk)
    if (!resetn) last_grant <= 1'b0;
    else if (grant) last_grant <= pick_data;
  // on a collision the requester that did not win last time gets the grant
  assign pick_data = data_req & (!inst_req | !last_grant);
`else
  assign pick_data = data_req;
`endif
  // outputs are gated by resetn so nothing is acknowledged while reset is asserted
  assign grant = resetn & (state == IDLE) & (inst_req | data_req);
  assign done  = resetn & (state == WAIT) & bus_data_ok;
  always_comb begin
    state_nxt    = IDLE;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    state_nxt    = state == IDLE ? (grant ? REQ : IDLE) :
                   state == REQ  ? (bus_addr_ok ? WAIT : REQ) :
                   state == WAIT ? (bus_data_ok ? IDLE : WAIT) : IDLE;
    inst_addr_ok = grant & !pick_data;
    data_addr_ok = grant & pick_data;
    bus_req      = resetn & (state == REQ);
    inst_data_ok = done & !owner;
    data_data_ok = done & owner;
    inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
    data_rdata   = data_data_ok ? bus_rdata : 32'h0;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wstrb <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner     <= pick_data;
        bus_wr    <= pick_data & data_wr;
        bus_wstrb <= pick_data ? data_wstrb : 4'h0;
        bus_addr  <= pick_data ? data_addr : inst_addr;
        bus_wdata <= pick_data ? data_wdata : 32'h0;
      end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus collision and reset-in-WAIT sequences for sram_arbiter.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [137:0] got;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [31:0] B = 32'h1c000000, F = 32'h1c000004, S = 32'h00001000, W = 32'hdeadbeef;
  always #5 clk = ~clk;
  sram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );
  assign got = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
                bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata};
  typedef struct {
    logic rn, ir; logic [31:0] ia;
    logic dr, dw; logic [3:0] ds; logic [31:0] da, dd;
    logic ao, bd; logic [31:0] rd;
    logic [137:0] exp;
  } vec_t;
  vec_t v[$];
  function automatic logic [137:0] ex(logic iao, logic ido, logic [31:0] ird, logic dao, logic ddo,
                                      logic [31:0] drd, logic breq, logic bwr, logic [3:0] bws,
                                      logic [31:0] ba, logic [31:0] bwd);
    return {iao, ido, ird, dao, ddo, drd, breq, bwr, bws, ba, bwd};
  endfunction
  task automatic drive(input logic rn, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [3:0] ds, input logic [31:0] da,
                       input logic [31:0] dd, input logic ao, input logic bd, input logic [31:0] rd);
    resetn = rn; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
    bus_addr_ok = ao; bus_data_ok = bd; bus_rdata = rd;
  endtask
  task automatic check(input string name, input logic [137:0] g, input logic [137:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, g, e);
    end
  endtask
  initial begin
    logic w;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.push_back('{0, 1, B, 0, 0, 4'h0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,0,0,0)});
    v.push_back('{0, 1, B, 1, 0, 4'h0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,0,0,0)});
    v.push_back('{1, 1, B, 0, 0, 4'h0, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,0,0,0,0)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,1,0,0,B,0)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,0,B,0)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h02800c0c, ex(0,1,32'h02800c0c,0,0,0,0,0,0,B,0)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 1, 32'h55, ex(0,0,0,0,0,0,0,0,0,B,0)});
    v.push_back('{1, 0, 0, 1, 1, 4'h3, S, W, 0, 0, 0, ex(0,0,0,1,0,0,0,0,0,B,0)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,1,4'h3,S,W)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,1,1,4'h3,S,W)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,1,4'h3,S,W)});
    v.push_back('{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h12345678, ex(0,0,0,0,1,32'h12345678,0,1,4'h3,S,W)});
    v.push_back('{1, 1, F, 0, 0, 4'h0, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,1,4'h3,S,W)});
    for (int i = 0; i < 5; i++)
      v.push_back('{1, 1, F, 1, 1, 4'hf, S, W, 0, 0, 0, ex(0,0,0,0,0,0,1,0,0,F,0)});
    v.push_back('{1, 1, F, 1, 1, 4'hf, S, W, 1, 0, 0, ex(0,0,0,0,0,0,1,0,0,F,0)});
    v.push_back('{1, 0, 0, 1, 1, 4'hf, S, W, 0, 1, 32'haa, ex(0,1,32'haa,0,0,0,0,0,0,F,0)});
    v.push_back('{1, 1, B, 1, 0, 4'h0, 32'h2000, 0, 0, 0, 0, ex(0,0,0,1,0,0,0,0,0,F,0)});
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].rn, v[i].ir, v[i].ia, v[i].dr, v[i].dw, v[i].ds, v[i].da, v[i].dd,
            v[i].ao, v[i].bd, v[i].rd);
      #1 check($sformatf("vec%0d", i), got, v[i].exp);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("coll_reset", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req}, 0);
    for (int t = 0; t < 4; t++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      w = (t % 2 == 0);
`else
      w = 1'b1;
`endif
      @(negedge clk);
      drive(1, 1, B, 1, 0, 0, S, 0, 0, 0, 0);
      #1 check($sformatf("coll%0d_grant", t), {inst_addr_ok, data_addr_ok}, w ? 2'b01 : 2'b10);
      @(negedge clk);
      drive(1, 1, B, 1, 0, 0, S, 0, 1, 0, 0);
      #1 check($sformatf("coll%0d_req", t), {inst_addr_ok, data_addr_ok, bus_req, bus_addr},
               {2'b00, 1'b1, w ? S : B});
      @(negedge clk);
      drive(1, 1, B, 1, 0, 0, S, 0, 0, 1, 32'hc0 + t);
      #1 check($sformatf("coll%0d_data", t),
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_rdata, data_rdata},
               w ? {4'b0001, 32'h0, 32'hc0 + t} : {4'b0010, 32'hc0 + t, 32'h0});
    end
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 4'hf, S, W, 0, 0, 0);
    #1 check("rst_wait_grant", data_addr_ok, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 check("rst_wait_req", bus_req, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("rst_wait_in_reset", {inst_data_ok, data_data_ok, bus_req}, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    #1 check("rst_wait_late_data", {inst_data_ok, data_data_ok, inst_rdata, data_rdata, bus_req, bus_addr}, 0);
    @(negedge clk);
    drive(1, 1, B, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("rst_wait_idle", {inst_addr_ok, bus_req}, 2'b10);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: none; all address/data widths are fixed at 32 bits, strobe at 4 bits.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 inst_req  in  1  fetch request, held until inst_addr_ok.
REQ-005 inst_addr  in  32  fetch byte address (read only).
REQ-006 inst_addr_ok  out  1  one-cycle pulse: fetch request accepted.
REQ-007 inst_data_ok  out  1  one-cycle pulse: fetch data valid on inst_rdata.
REQ-008 inst_rdata  out  32  fetch read data.
REQ-009 data_req  in  1  load/store request, held until data_addr_ok.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_wstrb  in  4  byte write strobe (store only).
REQ-012 data_addr  in  32  load/store word address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  one-cycle pulse: data request accepted.
REQ-015 data_data_ok  out  1  one-cycle pulse: load data valid / store complete.
REQ-016 data_rdata  out  32  load read data.
REQ-017 bus_req / bus_wr / bus_wstrb / bus_addr / bus_wdata  out  1/1/4/32/32  shared memory port request.
REQ-018 bus_addr_ok  in  1  shared port accepted the request this cycle.
REQ-019 bus_data_ok  in  1  shared port returns data / write ack this cycle.
REQ-020 bus_rdata  in  32  shared port read data.

Function
REQ-021 FSM states: IDLE, REQ, WAIT; at most one outstanding bus transaction.
REQ-022 IDLE: if inst_req or data_req, select winner per REQ-030, pulse winner's *_addr_ok in that cycle, latch {wr, wstrb, addr, wdata, owner} into bus registers, go to REQ; with no request, stay in IDLE.
REQ-023 Latched fetch: bus_wr = 0, bus_wstrb = 4'b0000, bus_wdata = 0.
REQ-024 REQ: bus_req = 1 with registered fields held stable; on bus_addr_ok go to WAIT; otherwise stay in REQ.
REQ-025 WAIT: bus_req = 0; on bus_data_ok pulse owner's *_data_ok in the same cycle (combinational), drive bus_rdata to owner's *_rdata, go to IDLE.
REQ-026 Non-owner *_data_ok stays 0; *_rdata holds bus_rdata only while its data_ok = 1, otherwise 0.
REQ-027 bus_addr_ok outside REQ and bus_data_ok outside WAIT are ignored.
REQ-028 Requests arriving in REQ/WAIT are not acknowledged; the requester holds them until the next IDLE.
REQ-029 Minimum transaction latency: grant (cycle 0), bus_req (cycle 1), data_ok no earlier than cycle 2; one IDLE bubble separates back-to-back transactions.
REQ-030 Arbitration when both requests are present in IDLE: data wins (fixed priority; see REQ-035 for the round-robin variant).

Reset
REQ-031 resetn = 0 at posedge: state -> IDLE; owner -> inst; last_grant -> inst; all bus registers -> 0.
REQ-032 Outputs while/after reset: bus_req = 0, all *_addr_ok / *_data_ok = 0, all rdata = 0.
REQ-033 Reset mid-transaction abandons it: no data_ok to either requester; a late bus_data_ok after reset is ignored per REQ-027.

Configuration
REQ-034 Macro SRAM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-035 Defined: on a collision the grant goes to the requester not in last_grant; last_grant updates on every grant; a sole requester always wins.
REQ-036 Undefined: fixed data priority per REQ-030; the last_grant register is not implemented.

Verification
REQ-037 Fetch only: inst_req = 1, addr 0x1c000000; bus_addr_ok at cycle 1, bus_data_ok at cycle 3 with rdata 0x02800c0c -> inst_addr_ok at cycle 0, bus_req only at cycle 1, inst_data_ok = 1 and inst_rdata = 0x02800c0c at cycle 3.
REQ-038 Store: data_req, wr = 1, wstrb 4'b0011, addr 0x1000, wdata 0xdeadbeef -> bus carries exactly these values in REQ; data_data_ok pulses once; inst_data_ok stays 0.
REQ-039 Collision, fixed priority: both requests held for 3 transactions -> order data, data, data; inst never granted while data_req = 1.
REQ-040 Collision, SRAM_ARB_ROUND_ROBIN_EN defined: both held -> grants alternate starting with data (last_grant = inst after reset): data, inst, data, inst.
REQ-041 Backpressure: bus_addr_ok held low 5 cycles -> bus_req = 1 and all fields stable for 5 cycles, no second grant.
REQ-042 Reset in WAIT, then bus_data_ok the following cycle -> both data_ok = 0, state IDLE, bus_req = 0.
